reg_status_file: RTL and testbench

- Tomasulo register file plus register-status (Qi) table.
- Each architectural register holds a data value and a producer tag. Tag 0 means the value is valid.
- Issue logic reads two source registers (value and tag) and renames a destination register to a reservation-station tag.
- The Common Data Bus (CDB) writes results back and clears matching tags.

---
 rtl/reg_status_pkg.sv | 16 +
 rtl/reg_status_read_port.sv | 36 +++
 rtl/reg_status_file.sv | 106 ++++++++++
 tb/tb_reg_status_file.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_status_pkg.sv
// Shared widths and types for the register file / register-status table.
package reg_status_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int TAG_W      = 5;
  localparam int DATA_W     = 32;

  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  // Tag 0 is never assigned to a reservation station; it marks a ready value.
  localparam tag_t NO_TAG = '0;

endpackage

// File: rtl/reg_status_read_port.sv
// Single-source operand lookup: selects one register's value and tag, and
// optionally substitutes the result currently on the CDB when that register
// is waiting for it.
import reg_status_pkg::*;

module reg_status_read_port #(
  parameter bit FWD_EN = 1'b0
) (
  input  data_t    val_arr [NUM_REGS],
  input  tag_t     tag_arr [NUM_REGS],
  input  reg_idx_t rd_idx,
  input  logic     cdb_bcast,
  input  tag_t     cdb_tag,
  input  data_t    cdb_val,
  output data_t    rd_val,
  output tag_t     rd_tag
);

  data_t cur_val;
  tag_t  cur_tag;
  logic  fwd_hit;

  // Look up the register and apply the CDB bypass when the register is waiting on it.
  always_comb begin
    cur_val = val_arr[rd_idx];
    cur_tag = tag_arr[rd_idx];
    fwd_hit = FWD_EN && cdb_bcast && (cur_tag != NO_TAG) && (cur_tag == cdb_tag);
    rd_val  = cur_val;
    rd_tag  = cur_tag;
    if (fwd_hit) begin
      rd_val = cdb_val;
      rd_tag = NO_TAG;
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// Tomasulo architectural register file with per-register producer tags (Qi).
// Optional build macro REG_STATUS_CDB_FORWARD_EN: a read in the same cycle as
// a matching CDB broadcast returns the broadcast value with tag 0. Without it
// the read returns the pre-broadcast state and the consumer snoops the CDB.
import reg_status_pkg::*;

module reg_status_file (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_read_en,
  input  logic [REG_ADDR_W-1:0] in_reg_1,
  input  logic [REG_ADDR_W-1:0] in_reg_2,
  input  logic                  in_bank_enable,
  input  logic [REG_ADDR_W-1:0] in_bank_reg,
  input  logic [TAG_W-1:0]      in_bank_tag,
  input  logic                  in_CDB_broadcast,
  input  logic [TAG_W-1:0]      in_CDB_tag,
  input  logic [DATA_W-1:0]     in_CDB_val,
  output logic                  out_enable,
  output logic [DATA_W-1:0]     out_val_1,
  output logic [DATA_W-1:0]     out_val_2,
  output logic [TAG_W-1:0]      out_tag_1,
  output logic [TAG_W-1:0]      out_tag_2
);

`ifdef REG_STATUS_CDB_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  data_t val_q [NUM_REGS];
  tag_t  tag_q [NUM_REGS];

  data_t rd_val_1, rd_val_2;
  tag_t  rd_tag_1, rd_tag_2;

  logic cdb_live;
  assign cdb_live = in_CDB_broadcast && (in_CDB_tag != NO_TAG);

  // Register state: CDB clears matching tags, then a rename of the same
  // register overrides the cleared tag while the CDB value is still kept.
  // Entry 0 is held at zero so it always reads as a ready zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= NO_TAG;
      end
    end else begin
      val_q[0] <= '0;
      tag_q[0] <= NO_TAG;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (cdb_live && (tag_q[i] == in_CDB_tag)) begin
          val_q[i] <= in_CDB_val;
          tag_q[i] <= NO_TAG;
        end
        if (in_bank_enable && (in_bank_reg == reg_idx_t'(i))) begin
          tag_q[i] <= in_bank_tag;
        end
      end
    end
  end

  reg_status_read_port #(.FWD_EN(FWD_EN)) u_read_port_1 (
    .val_arr   (val_q),
    .tag_arr   (tag_q),
    .rd_idx    (in_reg_1),
    .cdb_bcast (in_CDB_broadcast),
    .cdb_tag   (in_CDB_tag),
    .cdb_val   (in_CDB_val),
    .rd_val    (rd_val_1),
    .rd_tag    (rd_tag_1)
  );

  reg_status_read_port #(.FWD_EN(FWD_EN)) u_read_port_2 (
    .val_arr   (val_q),
    .tag_arr   (tag_q),
    .rd_idx    (in_reg_2),
    .cdb_bcast (in_CDB_broadcast),
    .cdb_tag   (in_CDB_tag),
    .cdb_val   (in_CDB_val),
    .rd_val    (rd_val_2),
    .rd_tag    (rd_tag_2)
  );

  // Capture read results from pre-edge state; hold them when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_enable <= 1'b0;
      out_val_1  <= '0;
      out_val_2  <= '0;
      out_tag_1  <= NO_TAG;
      out_tag_2  <= NO_TAG;
    end else begin
      out_enable <= in_read_en;
      if (in_read_en) begin
        out_val_1 <= rd_val_1;
        out_val_2 <= rd_val_2;
        out_tag_1 <= rd_tag_1;
        out_tag_2 <= rd_tag_2;
      end
    end
  end

endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: directed cases followed by random
// traffic, checked against an array-based model of the register semantics.
module tb_reg_status_file;

  logic        clk;
  logic        rst_n;
  logic        in_read_en;
  logic [4:0]  in_reg_1, in_reg_2;
  logic        in_bank_enable;
  logic [4:0]  in_bank_reg;
  logic [4:0]  in_bank_tag;
  logic        in_CDB_broadcast;
  logic [4:0]  in_CDB_tag;
  logic [31:0] in_CDB_val;
  logic        out_enable;
  logic [31:0] out_val_1, out_val_2;
  logic [4:0]  out_tag_1, out_tag_2;

  reg_status_file dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_read_en       (in_read_en),
    .in_reg_1         (in_reg_1),
    .in_reg_2         (in_reg_2),
    .in_bank_enable   (in_bank_enable),
    .in_bank_reg      (in_bank_reg),
    .in_bank_tag      (in_bank_tag),
    .in_CDB_broadcast (in_CDB_broadcast),
    .in_CDB_tag       (in_CDB_tag),
    .in_CDB_val       (in_CDB_val),
    .out_enable       (out_enable),
    .out_val_1        (out_val_1),
    .out_val_2        (out_val_2),
    .out_tag_1        (out_tag_1),
    .out_tag_2        (out_tag_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  t1;
    logic [4:0]  t2;
  } exp_t;

  exp_t exp_q [$];
  exp_t last_exp;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];

`ifdef REG_STATUS_CDB_FORWARD_EN
  localparam bit MODEL_FWD = 1'b1;
`else
  localparam bit MODEL_FWD = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req)
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    else
      pass_cnt++;
  endtask

  // What a read of register r returns this cycle, given the model state
  // before the edge and the broadcast on the bus.
  function automatic void model_read(input int r, input logic cb, input logic [4:0] ct,
                                     input logic [31:0] cv,
                                     output logic [31:0] v, output logic [4:0] t);
    v = m_val[r];
    t = m_tag[r];
    if (MODEL_FWD && cb && ct != 0 && t == ct) begin
      v = cv;
      t = 0;
    end
  endfunction

  // Advance the model across one edge: results land first, a rename then
  // decides the final tag of its register. Register 0 never changes.
  function automatic void model_update(input logic be, input logic [4:0] br, input logic [4:0] bt,
                                       input logic cb, input logic [4:0] ct, input logic [31:0] cv);
    if (cb && ct != 0)
      for (int i = 1; i < 32; i++)
        if (m_tag[i] == ct) begin
          m_val[i] = cv;
          m_tag[i] = 0;
        end
    if (be && br != 0)
      m_tag[br] = bt;
  endfunction

  task automatic cyc(input logic re, input logic [4:0] r1, input logic [4:0] r2,
                     input logic be, input logic [4:0] br, input logic [4:0] bt,
                     input logic cb, input logic [4:0] ct, input logic [31:0] cv);
    exp_t e;
    @(negedge clk);
    in_read_en       = re;
    in_reg_1         = r1;
    in_reg_2         = r2;
    in_bank_enable   = be;
    in_bank_reg      = br;
    in_bank_tag      = bt;
    in_CDB_broadcast = cb;
    in_CDB_tag       = ct;
    in_CDB_val       = cv;
    if (re) begin
      model_read(int'(r1), cb, ct, cv, e.v1, e.t1);
      model_read(int'(r2), cb, ct, cv, e.v2, e.t2);
      exp_q.push_back(e);
    end
    model_update(be, br, bt, cb, ct, cv);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: pops the scoreboard on each out_enable pulse; between pulses the
  // outputs must hold the last delivered result.
  initial begin
    last_exp = '{v1: 32'd0, v2: 32'd0, t1: 5'd0, t2: 5'd0};
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (out_enable) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_enable", 32'(out_enable), 32'd0);
          end else begin
            last_exp = exp_q.pop_front();
            chk("out_val_1", out_val_1, last_exp.v1);
            chk("out_val_2", out_val_2, last_exp.v2);
            chk("out_tag_1", 32'(out_tag_1), 32'(last_exp.t1));
            chk("out_tag_2", 32'(out_tag_2), 32'(last_exp.t2));
          end
        end else begin
          chk("hold_val_1", out_val_1, last_exp.v1);
          chk("hold_tag_2", 32'(out_tag_2), 32'(last_exp.t2));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 0;
      m_tag[i] = 0;
    end
    rst_n = 1'b0;
    in_read_en = 0; in_reg_1 = 0; in_reg_2 = 0;
    in_bank_enable = 0; in_bank_reg = 0; in_bank_tag = 0;
    in_CDB_broadcast = 0; in_CDB_tag = 0; in_CDB_val = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_enable", 32'(out_enable), 32'd0);
    chk("rst_out_val_1", out_val_1, 32'd0);
    chk("rst_out_val_2", out_val_2, 32'd0);
    chk("rst_out_tag_1", 32'(out_tag_1), 32'd0);
    chk("rst_out_tag_2", 32'(out_tag_2), 32'd0);
    rst_n = 1'b1;

    // Directed cases.
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 1, 5, 1, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 32'd7);
    cyc(1, 5, 5, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3, 2, 0, 0, 0);
    cyc(0, 0, 0, 1, 4, 2, 0, 0, 0);
    cyc(1, 3, 4, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 32'hABCD);
    cyc(1, 3, 4, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 6, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 6, 4, 1, 3, 32'd9);
    cyc(1, 6, 6, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 5, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'h55);
    cyc(0, 0, 0, 1, 5, 1, 0, 0, 0);
    cyc(1, 5, 2, 0, 0, 0, 1, 1, 32'd7);
    cyc(1, 5, 0, 1, 5, 7, 0, 0, 0);
    cyc(1, 5, 5, 0, 0, 0, 0, 0, 0);
    idle();
    idle();

    // Random traffic with narrow tag/index ranges so collisions are frequent.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] r1, r2, br;
      r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      br = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), r1, r2,
          1'($urandom_range(0, 1)), br, 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    idle();
    idle();
    idle();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
